mock_sram_1rw_fold: RTL

Parametrised single-port mock SRAM for the physical-design flow: it stands in for large 1RW macros (L2 TLB, cache data/tag arrays) with a small physical array. It keeps the real macro's port shape and read latency, folds the logical address onto few rows by XOR, and supports masked writes. It adds deterministic read data, configurable read latency and an alias-detection counter, so folded-array collisions are observable in simulation.

---
 rtl/mock_sram_pkg.sv | 40 ++++
 rtl/mock_sram_rd_pipe.sv | 63 ++++++
 rtl/mock_sram_1rw_fold.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mock_sram_pkg.sv
// mock_sram_pkg
// Shared definitions for the folded mock SRAM:
//   - ALIAS_CNT_W : width of the saturating alias counter
//   - fold_addr   : XOR-folds a logical address onto a physical row index
//   - params_ok   : elaboration-time sanity check of the geometry
package mock_sram_pkg;

    localparam int ALIAS_CNT_W = 16;

    // XOR of consecutive idx_w-bit chunks of addr (the last chunk is
    // implicitly zero-extended). When addr_w <= idx_w this is addr itself.
    function automatic logic [63:0] fold_addr(input logic [63:0] addr,
                                              input int addr_w,
                                              input int idx_w);
        logic [63:0] a;
        logic [63:0] lane_m;
        logic [63:0] acc;
        a      = addr & ((64'd1 << addr_w) - 64'd1);
        lane_m = (64'd1 << idx_w) - 64'd1;
        acc    = '0;
        for (int c = 0; c < addr_w; c += idx_w) begin
            acc = acc ^ ((a >> c) & lane_m);
        end
        return acc;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int data_w,
                                     input int mask_gran,
                                     input int phys_rows,
                                     input int read_lat);
        return is_pow2(phys_rows)
            && (mask_gran > 0) && ((data_w % mask_gran) == 0)
            && ((read_lat == 1) || (read_lat == 2));
    endfunction

endpackage

// File: rtl/mock_sram_rd_pipe.sv
// mock_sram_rd_pipe
// Delay line for completed read samples {valid, data, alias}.
// DEPTH = 0 is a pure pass-through (the top's output register supplies
// the single cycle of latency).
// Ports:
//   clk      clock, rising edge
//   clr      synchronous clear (drops every in-flight read)
//   i_vld / i_data / i_alias   sample entering the pipe
//   o_vld / o_data / o_alias   sample leaving the pipe
import mock_sram_pkg::*;

module mock_sram_rd_pipe #(
    parameter int DATA_W = 45,
    parameter int DEPTH  = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_alias,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic              o_alias
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = &{1'b0, clk, clr};
            assign o_vld    = i_vld;
            assign o_data   = i_data;
            assign o_alias  = i_alias;
        end else begin : g_pipe
            logic              r_vld   [DEPTH];
            logic [DATA_W-1:0] r_data  [DEPTH];
            logic              r_alias [DEPTH];

            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_vld[i]   <= 1'b0;
                        r_data[i]  <= '0;
                        r_alias[i] <= 1'b0;
                    end
                end else begin
                    r_vld[0]   <= i_vld;
                    r_data[0]  <= i_data;
                    r_alias[0] <= i_alias;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i]   <= r_vld[i-1];
                        r_data[i]  <= r_data[i-1];
                        r_alias[i] <= r_alias[i-1];
                    end
                end
            end

            assign o_vld   = r_vld[DEPTH-1];
            assign o_data  = r_data[DEPTH-1];
            assign o_alias = r_alias[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mock_sram_1rw_fold.sv
// mock_sram_1rw_fold
// Single-port mock SRAM standing in for a large 1RW macro. The logical
// address is XOR-folded onto PHYS_ROWS rows; each row keeps the full
// logical address of its last writer as a tag so that reads landing on a
// row owned by another address are flagged (alias_hit) and counted.
// Ports:
//   RW0_clk    clock, rising edge
//   RW0_reset  synchronous active-high reset
//   RW0_addr   logical address
//   RW0_en     access enable
//   RW0_wmode  1 = write, 0 = read
//   RW0_wdata  write data
//   RW0_wmask  per-lane write enable (MASK_GRAN bits per lane)
//   RW0_rdata  read data, READ_LAT cycles after issue, holds otherwise
//   alias_hit  one-cycle pulse with the rdata update of an aliased read
//   alias_cnt  saturating count of alias hits
import mock_sram_pkg::*;

module mock_sram_1rw_fold #(
    parameter int DATA_W    = 45,
    parameter int ADDR_W    = 9,
    parameter int PHYS_ROWS = 16,
    parameter int MASK_GRAN = 45,
    parameter int READ_LAT  = 1,
    localparam int IDX_W    = $clog2(PHYS_ROWS),
    localparam int MASK_W   = DATA_W / MASK_GRAN
) (
    input  logic                   RW0_clk,
    input  logic                   RW0_reset,
    input  logic [ADDR_W-1:0]      RW0_addr,
    input  logic                   RW0_en,
    input  logic                   RW0_wmode,
    input  logic [DATA_W-1:0]      RW0_wdata,
    input  logic [MASK_W-1:0]      RW0_wmask,
    output logic [DATA_W-1:0]      RW0_rdata,
    output logic                   alias_hit,
    output logic [ALIAS_CNT_W-1:0] alias_cnt
);

    generate
        if (!params_ok(DATA_W, MASK_GRAN, PHYS_ROWS, READ_LAT)) begin : g_bad_params
            $error("mock_sram_1rw_fold: illegal DATA_W/MASK_GRAN/PHYS_ROWS/READ_LAT");
        end
    endgenerate

    logic [DATA_W-1:0]      r_mem [PHYS_ROWS];
    logic [ADDR_W-1:0]      r_tag [PHYS_ROWS];
    logic [PHYS_ROWS-1:0]   r_valid;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_hit;
    logic [ALIAS_CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic              w_wr;
    logic              w_rd;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_alias;
    logic              w_p_vld;
    logic [DATA_W-1:0] w_p_data;
    logic              w_p_alias;

    assign w_idx = IDX_W'(fold_addr(64'(RW0_addr), ADDR_W, IDX_W));

    // Accesses presented while reset is high are dropped entirely.
    assign w_wr = RW0_en &  RW0_wmode & ~RW0_reset;
    assign w_rd = RW0_en & ~RW0_wmode & ~RW0_reset;

    // Sampled in the issue cycle, so a later write cannot leak into an
    // in-flight read.
    assign w_rd_data  = r_valid[w_idx] ? r_mem[w_idx] : '0;
    assign w_rd_alias = r_valid[w_idx] && (r_tag[w_idx] != RW0_addr);

    // Data and tags are deliberately not reset; only the valid bits are.
    always_ff @(posedge RW0_clk) begin
        if (w_wr) begin
            for (int l = 0; l < MASK_W; l++) begin
                if (RW0_wmask[l]) begin
                    r_mem[w_idx][l*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[l*MASK_GRAN +: MASK_GRAN];
                end
            end
            r_tag[w_idx] <= RW0_addr;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            r_valid <= '0;
        end else if (w_wr) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    mock_sram_rd_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (READ_LAT - 1)
    ) u_rd_pipe (
        .clk     (RW0_clk),
        .clr     (RW0_reset),
        .i_vld   (w_rd),
        .i_data  (w_rd_data),
        .i_alias (w_rd_alias),
        .o_vld   (w_p_vld),
        .o_data  (w_p_data),
        .o_alias (w_p_alias)
    );

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_p_vld) begin
            r_rdata <= w_p_data;
            r_hit   <= w_p_alias;
            if (w_p_alias && (r_cnt != '1)) begin
                r_cnt <= r_cnt + ALIAS_CNT_W'(1);
            end
        end else begin
            r_hit <= 1'b0;
        end
    end

    assign RW0_rdata = r_rdata;
    assign alias_hit = r_hit;
    assign alias_cnt = r_cnt;

endmodule
